// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - index and counter types shared by the TCDM port arbiter
package tcdm_arb_pkg;

  localparam int unsigned TCDM_ARB_NR_MASTERS = 4;
  localparam int unsigned IDX_WIDTH =
    ($clog2(TCDM_ARB_NR_MASTERS) > 1) ? $clog2(TCDM_ARB_NR_MASTERS) : 1;

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef logic [31:0]          cnt_t;

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// rtl/tcdm_arb_id_fifo.sv - in-order FIFO of granted master indices awaiting a response
module tcdm_arb_id_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  idx_t push_idx_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output idx_t head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  idx_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= push_idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/tcdm_port_arbiter.sv
// rtl/tcdm_port_arbiter.sv - round-robin share of one TCDM slave port with in-order response routing
// Optional perf counters: TCDM_ARB_PERF_CNT_EN
module tcdm_port_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NR_MASTERS      = TCDM_ARB_NR_MASTERS,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_MASTERS-1:0]          m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0]     m_add_i,
  input  logic [NR_MASTERS-1:0]          m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
  output logic [NR_MASTERS-1:0]          m_gnt_o,
  output logic [NR_MASTERS-1:0]          m_r_valid_o,
  output logic [DATA_WIDTH-1:0]          m_r_rdata_o,
  output logic                           m_r_opc_o,
  output logic                           s_req_o,
  output logic [ADDR_WIDTH-1:0]          s_add_o,
  output logic                           s_wen_o,
  output logic [DATA_WIDTH-1:0]          s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        s_be_o,
  input  logic                           s_gnt_i,
  input  logic                           s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          s_r_rdata_i,
  input  logic                           s_r_opc_i,
  output logic                           err_o,
  input  logic                           clr_cnt_i,
  output logic [NR_MASTERS*32-1:0]       cnt_gnt_o,
  output cnt_t                           cnt_stall_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;

  idx_t r_rr_ptr;
  logic r_lock;
  idx_t r_lock_idx;
  logic r_err;

  logic w_rr_found;
  idx_t w_rr_idx;
  idx_t w_probe;
  idx_t w_cand;
  idx_t w_rr_next;
  logic w_any_req;
  logic w_grant;
  logic w_pop;
  logic w_full;
  logic w_empty;
  idx_t w_head;

  logic [ADDR_WIDTH-1:0] w_add   [NR_MASTERS];
  logic [DATA_WIDTH-1:0] w_wdata [NR_MASTERS];
  logic [BW-1:0]         w_be    [NR_MASTERS];

  for (genvar g = 0; g < NR_MASTERS; g++) begin : g_unpack
    assign w_add[g]   = m_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_be[g]    = m_be_i[g*BW +: BW];
  end

  // First requester at or after rr_ptr, wrapping modulo NR_MASTERS.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_rr_ptr;
    w_probe    = r_rr_ptr;
    for (int k = 0; k < NR_MASTERS; k++) begin
      if (!w_rr_found && m_req_i[w_probe]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_probe;
      end
      w_probe = (w_probe == idx_t'(NR_MASTERS - 1)) ? '0 : w_probe + 1'b1;
    end
  end

  assign w_cand    = r_lock ? r_lock_idx : w_rr_idx;
  assign w_rr_next = (w_cand == idx_t'(NR_MASTERS - 1)) ? '0 : w_cand + 1'b1;
  assign w_any_req = |m_req_i;

  // Full is taken from the registered count so a same-cycle pop cannot unmask a request.
  assign s_req_o   = (w_any_req || r_lock) && !w_full;
  assign s_add_o   = w_add[w_cand];
  assign s_wen_o   = m_wen_i[w_cand];
  assign s_wdata_o = w_wdata[w_cand];
  assign s_be_o    = w_be[w_cand];

  assign w_grant = s_req_o && s_gnt_i;
  assign m_gnt_o = w_grant ? (NR_MASTERS'(1) << w_cand) : '0;

  assign w_pop       = s_r_valid_i && !w_empty;
  assign m_r_valid_o = w_pop ? (NR_MASTERS'(1) << w_head) : '0;
  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;
  assign err_o       = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_rr_next;
        r_lock   <= 1'b0;
      end else if (s_req_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_cand;
      end
      if (s_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_grant),
    .push_idx_i (w_cand),
    .pop_i      (w_pop),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .head_o     (w_head)
  );

`ifdef TCDM_ARB_PERF_CNT_EN
  cnt_t r_cnt_gnt [NR_MASTERS];
  cnt_t r_cnt_stall;
  logic w_stall;

  assign w_stall = ($countones(m_req_i) > 1) || (w_full && w_any_req);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      for (int i = 0; i < NR_MASTERS; i++) r_cnt_gnt[i] <= '0;
      r_cnt_stall <= '0;
    end else begin
      for (int i = 0; i < NR_MASTERS; i++) begin
        if (m_gnt_o[i]) r_cnt_gnt[i] <= r_cnt_gnt[i] + 1'b1;
      end
      if (w_stall) r_cnt_stall <= r_cnt_stall + 1'b1;
    end
  end

  for (genvar g = 0; g < NR_MASTERS; g++) begin : g_cnt_pack
    assign cnt_gnt_o[g*32 +: 32] = r_cnt_gnt[g];
  end
  assign cnt_stall_o = r_cnt_stall;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_cnt_i;
  assign cnt_gnt_o    = '0;
  assign cnt_stall_o  = '0;
`endif

endmodule
